// File: rtl/moxielite_wb_decoder.sv
// moxielite_wb_decoder: Wishbone master port fanned out to four slaves by address[31:28].
// Defining MOXIELITE_WB_DECODER_TIMEOUT_EN adds a slave-wait limit that reports a bus error.
module moxielite_wb_decoder #(
    parameter logic [3:0] S0_HI   = 4'h0,
    parameter logic [3:0] S1_HI   = 4'h1,
    parameter logic [3:0] S2_HI   = 4'h2,
    parameter logic [3:0] S3_HI   = 4'hF,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    input  logic [1:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic [15:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [31:0] s_adr_o,
    output logic [15:0] s_dat_o,
    output logic [1:0]  s_sel_o,
    output logic        s_we_o,
    output logic [3:0]  s_cyc_o,
    output logic [3:0]  s_stb_o,
    input  logic [63:0] s_dat_i,
    input  logic [3:0]  s_ack_i,
    input  logic        err_clr_i,
    output logic        err_o,
    output logic [31:0] err_adr_o
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        ACK,
        ERR,
        TURN
    } state_t;

    localparam logic [15:0] ERR_DATA = 16'hDEAD;

    state_t      state;
    logic [1:0]  slave_idx;
    logic        bus_req;
    logic [3:0]  adr_hit;
    logic        adr_mapped;
    logic [1:0]  hit_idx;
    logic [3:0]  hit_onehot;
    logic        slave_ack;
    logic [15:0] slave_rdata;

    assign bus_req = wbs_cyc_i & wbs_stb_i;

    // Lowest-numbered slave wins when several parameters name the same region.
    always_comb begin
        adr_hit[0] = (wbs_adr_i[31:28] == S0_HI);
        adr_hit[1] = (wbs_adr_i[31:28] == S1_HI);
        adr_hit[2] = (wbs_adr_i[31:28] == S2_HI);
        adr_hit[3] = (wbs_adr_i[31:28] == S3_HI);
        adr_mapped = |adr_hit;
        if (adr_hit[0]) begin
            hit_idx = 2'd0;
        end else if (adr_hit[1]) begin
            hit_idx = 2'd1;
        end else if (adr_hit[2]) begin
            hit_idx = 2'd2;
        end else begin
            hit_idx = 2'd3;
        end
        hit_onehot = 4'b0001 << hit_idx;
    end

    assign slave_ack   = s_ack_i[slave_idx];
    assign slave_rdata = s_dat_i[{slave_idx, 4'b0000} +: 16];

`ifdef MOXIELITE_WB_DECODER_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       wait_expired;

    assign wait_expired = (wait_cnt == TIMEOUT - 8'd1);
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            slave_idx <= 2'd0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 16'h0000;
            s_adr_o   <= 32'h0000_0000;
            s_dat_o   <= 16'h0000;
            s_sel_o   <= 2'b00;
            s_we_o    <= 1'b0;
            s_cyc_o   <= 4'b0000;
            s_stb_o   <= 4'b0000;
            err_o     <= 1'b0;
            err_adr_o <= 32'h0000_0000;
`ifdef MOXIELITE_WB_DECODER_TIMEOUT_EN
            wait_cnt  <= 8'd0;
`endif
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 16'h0000;
            // A bus error raised on this same edge overrides the clear below.
            if (err_clr_i) begin
                err_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus_req) begin
                        s_adr_o <= wbs_adr_i;
                        s_dat_o <= wbs_dat_i;
                        s_sel_o <= wbs_sel_i;
                        s_we_o  <= wbs_we_i;
                        if (adr_mapped) begin
                            state     <= BUSY;
                            slave_idx <= hit_idx;
                            s_cyc_o   <= hit_onehot;
                            s_stb_o   <= hit_onehot;
`ifdef MOXIELITE_WB_DECODER_TIMEOUT_EN
                            wait_cnt  <= 8'd0;
`endif
                        end else begin
                            state     <= ERR;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= ERR_DATA;
                            err_o     <= 1'b1;
                            err_adr_o <= wbs_adr_i;
                        end
                    end
                end

                BUSY: begin
                    if (!wbs_cyc_i) begin
                        state   <= TURN;
                        s_cyc_o <= 4'b0000;
                        s_stb_o <= 4'b0000;
                    end else if (slave_ack) begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= slave_rdata;
                        s_cyc_o   <= 4'b0000;
                        s_stb_o   <= 4'b0000;
`ifdef MOXIELITE_WB_DECODER_TIMEOUT_EN
                    end else if (wait_expired) begin
                        state     <= ERR;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= ERR_DATA;
                        s_cyc_o   <= 4'b0000;
                        s_stb_o   <= 4'b0000;
                        err_o     <= 1'b1;
                        err_adr_o <= s_adr_o;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end

                ACK: begin
                    state <= TURN;
                end

                ERR: begin
                    state <= TURN;
                end

                TURN: begin
                    state <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    s_cyc_o <= 4'b0000;
                    s_stb_o <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moxielite_wb_decoder.sv
// Self-checking bench for moxielite_wb_decoder: directed scenarios plus randomized
// accesses compared against a transaction-level model of the decoder.
module tb_moxielite_wb_decoder;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] wbs_adr_i;
    logic [15:0] wbs_dat_i;
    logic [1:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [15:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic [31:0] s_adr_o;
    logic [15:0] s_dat_o;
    logic [1:0]  s_sel_o;
    logic        s_we_o;
    logic [3:0]  s_cyc_o;
    logic [3:0]  s_stb_o;
    logic [63:0] s_dat_i;
    logic [3:0]  s_ack_i;
    logic        err_clr_i;
    logic        err_o;
    logic [31:0] err_adr_o;

    int          checks = 0;
    int          errors = 0;
    logic        exp_err;
    logic [31:0] exp_eadr;

    moxielite_wb_decoder #(
        .S0_HI  (4'h0),
        .S1_HI  (4'h1),
        .S2_HI  (4'h2),
        .S3_HI  (4'hF),
        .TIMEOUT(8'd4)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_we_i (wbs_we_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .err_clr_i(err_clr_i),
        .err_o    (err_o),
        .err_adr_o(err_adr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decode: first entry of the slave table whose region matches, -1 if none.
    function automatic int exp_slave(input logic [31:0] adr);
        logic [3:0] hi_tab [4];
        hi_tab[0] = 4'h0;
        hi_tab[1] = 4'h1;
        hi_tab[2] = 4'h2;
        hi_tab[3] = 4'hF;
        for (int n = 0; n < 4; n++) begin
            if (adr[31:28] == hi_tab[n]) return n;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_idle();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        s_ack_i   = 4'b0000;
        err_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i     = 1'b1;
        wbs_adr_i = 32'h1000_0000;
        wbs_dat_i = 16'hFFFF;
        wbs_sel_i = 2'b11;
        wbs_we_i  = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        s_ack_i   = 4'hF;
        err_clr_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o} !== 25'd0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: got ack=%b dat=%h cyc=%b stb=%b, expected all zero",
                     wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o);
        end
        checks++;
        if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !== 51'd0) begin
            errors++;
            $display("[TB] FAIL reset_latched: got adr=%h dat=%h sel=%b we=%b, expected all zero",
                     s_adr_o, s_dat_o, s_sel_o, s_we_o);
        end
        checks++;
        if ({err_o, err_adr_o} !== 33'd0) begin
            errors++;
            $display("[TB] FAIL reset_err: got err=%b adr=%h, expected 0/0", err_o, err_adr_o);
        end
        bus_idle();
        rst_i = 1'b0;
        tick();
        checks++;
        if (s_stb_o !== 4'b0000 || wbs_ack_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_idle: got stb=%b ack=%b, expected 0000/0", s_stb_o, wbs_ack_o);
        end
    endtask

    task automatic test_read_slave1();
        s_dat_i   = {16'hA3A3, 16'hA2A2, 16'hBEEF, 16'hA0A0};
        wbs_adr_i = 32'h1000_0010;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 2'b11;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        tick();
        checks++;
        if (s_stb_o !== 4'b0010 || s_cyc_o !== 4'b0010 || wbs_ack_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read1_busy: got stb=%b cyc=%b ack=%b, expected 0010/0010/0", s_stb_o, s_cyc_o, wbs_ack_o);
        end
        checks++;
        if (s_adr_o !== 32'h1000_0010 || s_we_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read1_latch: got adr=%h we=%b, expected 10000010/0", s_adr_o, s_we_o);
        end
        s_ack_i = 4'b0010;
        tick();
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 16'hBEEF || s_stb_o !== 4'b0000 || err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read1_ack: got ack=%b dat=%h stb=%b err=%b, expected 1/beef/0000/0",
                     wbs_ack_o, wbs_dat_o, s_stb_o, err_o);
        end
        bus_idle();
        tick();
        checks++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL read1_turn: got ack=%b dat=%h, expected 0/0000", wbs_ack_o, wbs_dat_o);
        end
        tick();
    endtask

    task automatic test_unmapped_write();
        wbs_adr_i = 32'h3000_0000;
        wbs_dat_i = 16'h1234;
        wbs_sel_i = 2'b01;
        wbs_we_i  = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        tick();
        checks++;
        if (s_stb_o !== 4'b0000 || s_cyc_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL unmapped_no_strobe: got stb=%b cyc=%b, expected 0000", s_stb_o, s_cyc_o);
        end
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 16'hDEAD) begin
            errors++;
            $display("[TB] FAIL unmapped_ack: got ack=%b dat=%h, expected 1/dead", wbs_ack_o, wbs_dat_o);
        end
        checks++;
        if (err_o !== 1'b1 || err_adr_o !== 32'h3000_0000) begin
            errors++;
            $display("[TB] FAIL unmapped_err: got err=%b adr=%h, expected 1/30000000", err_o, err_adr_o);
        end
        checks++;
        if ({s_dat_o, s_sel_o, s_we_o} !== {16'h1234, 2'b01, 1'b1}) begin
            errors++;
            $display("[TB] FAIL unmapped_latch: got dat=%h sel=%b we=%b, expected 1234/01/1", s_dat_o, s_sel_o, s_we_o);
        end
        bus_idle();
        tick();
        checks++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 16'h0000 || err_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unmapped_turn: got ack=%b dat=%h err=%b, expected 0/0000/1", wbs_ack_o, wbs_dat_o, err_o);
        end
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checks++;
        if (err_o !== 1'b0 || err_adr_o !== 32'h3000_0000) begin
            errors++;
            $display("[TB] FAIL err_clear: got err=%b adr=%h, expected 0/30000000", err_o, err_adr_o);
        end
        wbs_adr_i = 32'h7ABC_0000;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || err_adr_o !== 32'h7ABC_0000 || wbs_ack_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_set_wins: got err=%b adr=%h ack=%b, expected 1/7abc0000/1", err_o, err_adr_o, wbs_ack_o);
        end
        bus_idle();
        tick();
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

    task automatic test_timeout();
        int bad;
        bad       = 0;
        s_dat_i   = {48'h0, 16'h5A5A};
        wbs_adr_i = 32'h0000_0040;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
`ifdef MOXIELITE_WB_DECODER_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            tick();
            if (s_stb_o !== 4'b0001 || wbs_ack_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL timeout_wait: got %0d bad strobe cycles, expected 0", bad);
        end
        tick();
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 16'hDEAD || s_stb_o !== 4'b0000 ||
            err_o !== 1'b1 || err_adr_o !== 32'h0000_0040) begin
            errors++;
            $display("[TB] FAIL timeout_err: got ack=%b dat=%h stb=%b err=%b adr=%h, expected 1/dead/0000/1/00000040",
                     wbs_ack_o, wbs_dat_o, s_stb_o, err_o, err_adr_o);
        end
        bus_idle();
        tick();
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        s_ack_i = 4'b0001;
        tick();
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 16'h5A5A || err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_ack_wins: got ack=%b dat=%h err=%b, expected 1/5a5a/0", wbs_ack_o, wbs_dat_o, err_o);
        end
        bus_idle();
        tick();
        tick();
`else
        for (int c = 0; c < 300; c++) begin
            tick();
            if (s_stb_o !== 4'b0001 || wbs_ack_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL no_timeout_hold: got %0d bad strobe cycles, expected 0", bad);
        end
        bus_idle();
        tick();
        checks++;
        if (s_stb_o !== 4'b0000 || wbs_ack_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_timeout_release: got stb=%b ack=%b err=%b, expected 0000/0/0", s_stb_o, wbs_ack_o, err_o);
        end
        tick();
`endif
    endtask

    task automatic test_abort();
        wbs_adr_i = 32'h2000_0100;
        wbs_dat_i = 16'($urandom);
        wbs_we_i  = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        tick();
        checks++;
        if (s_stb_o !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL abort_busy: got stb=%b, expected 0100", s_stb_o);
        end
        wbs_cyc_i = 1'b0;
        tick();
        s_ack_i = 4'b0100;
        checks++;
        if (s_stb_o !== 4'b0000 || s_cyc_o !== 4'b0000 || wbs_ack_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_drop: got stb=%b cyc=%b ack=%b, expected 0000/0000/0", s_stb_o, s_cyc_o, wbs_ack_o);
        end
        tick();
        checks++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL abort_no_ack: got ack=%b dat=%h, expected 0/0000", wbs_ack_o, wbs_dat_o);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_reset_midflight();
        logic [15:0] d;
        d         = 16'($urandom);
        wbs_adr_i = 32'h2000_0000;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        tick();
        tick();
        checks++;
        if (s_stb_o !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL midreset_busy2: got stb=%b, expected 0100", s_stb_o);
        end
        rst_i = 1'b1;
        tick();
        checks++;
        if (s_stb_o !== 4'b0000 || s_cyc_o !== 4'b0000 || wbs_ack_o !== 1'b0 || wbs_dat_o !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midreset_abort: got stb=%b cyc=%b ack=%b dat=%h, expected 0000/0000/0/0000",
                     s_stb_o, s_cyc_o, wbs_ack_o, wbs_dat_o);
        end
        rst_i = 1'b0;
        bus_idle();
        tick();
        s_dat_i   = {16'h0, d, 32'h0};
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        tick();
        s_ack_i = 4'b0100;
        tick();
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_dat_o !== d) begin
            errors++;
            $display("[TB] FAIL midreset_recover: got ack=%b dat=%h, expected 1/%h", wbs_ack_o, wbs_dat_o, d);
        end
        bus_idle();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] d1;
        logic [15:0] d2;
        d1        = 16'($urandom);
        d2        = 16'($urandom);
        s_dat_i   = {16'($urandom), 16'($urandom), d1, 16'($urandom)};
        wbs_adr_i = 32'h1000_0100;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        tick();
        s_ack_i = 4'b1000;
        tick();
        checks++;
        if (s_stb_o !== 4'b0010 || wbs_ack_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_ack_ignored: got stb=%b ack=%b, expected 0010/0", s_stb_o, wbs_ack_o);
        end
        s_ack_i = 4'b0010;
        tick();
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_dat_o !== d1) begin
            errors++;
            $display("[TB] FAIL b2b_first_ack: got ack=%b dat=%h, expected 1/%h", wbs_ack_o, wbs_dat_o, d1);
        end
        s_ack_i        = 4'b0000;
        wbs_adr_i      = 32'h1000_0200;
        s_dat_i[31:16] = d2;
        tick();
        checks++;
        if (wbs_ack_o !== 1'b0 || s_stb_o !== 4'b0000 || wbs_dat_o !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL b2b_turn: got ack=%b stb=%b dat=%h, expected 0/0000/0000", wbs_ack_o, s_stb_o, wbs_dat_o);
        end
        tick();
        checks++;
        if (wbs_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got ack=%b stb=%b, expected 0/0000", wbs_ack_o, s_stb_o);
        end
        tick();
        checks++;
        if (s_stb_o !== 4'b0010 || s_adr_o !== 32'h1000_0200) begin
            errors++;
            $display("[TB] FAIL b2b_second_start: got stb=%b adr=%h, expected 0010/10000200", s_stb_o, s_adr_o);
        end
        s_ack_i = 4'b0010;
        tick();
        checks++;
        if (wbs_ack_o !== 1'b1 || wbs_dat_o !== d2) begin
            errors++;
            $display("[TB] FAIL b2b_second_ack: got ack=%b dat=%h, expected 1/%h", wbs_ack_o, wbs_dat_o, d2);
        end
        bus_idle();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [15:0] sd [4];
        logic [31:0] adr;
        logic [3:0]  oh;
        logic [3:0]  stray;
        logic [15:0] exp_dat;
        int          n;
        int          delay;
        logic        clr;
        int          bad;
        for (int t = 0; t < 40; t++) begin
            adr = $urandom;
            case ($urandom_range(0, 4))
                0:       adr[31:28] = 4'h0;
                1:       adr[31:28] = 4'h1;
                2:       adr[31:28] = 4'h2;
                3:       adr[31:28] = 4'hF;
                default: adr[31:28] = 4'($urandom_range(3, 14));
            endcase
            for (int k = 0; k < 4; k++) sd[k] = 16'($urandom);
            s_dat_i   = {sd[3], sd[2], sd[1], sd[0]};
            wbs_adr_i = adr;
            wbs_dat_i = 16'($urandom);
            wbs_sel_i = 2'($urandom);
            wbs_we_i  = 1'($urandom);
            delay     = $urandom_range(1, 3);
            clr       = ($urandom_range(0, 3) == 0);
            n         = exp_slave(adr);
            err_clr_i = clr;
            wbs_cyc_i = 1'b1;
            wbs_stb_i = 1'b1;
            tick();
            err_clr_i = 1'b0;
            if (n < 0) begin
                exp_err  = 1'b1;
                exp_eadr = adr;
                exp_dat  = 16'hDEAD;
            end else begin
                if (clr) exp_err = 1'b0;
                exp_dat = sd[n];
                oh      = 4'b0000;
                oh[n]   = 1'b1;
                bad     = 0;
                for (int b = 1; b <= delay; b++) begin
                    if (s_stb_o !== oh || s_cyc_o !== oh || wbs_ack_o !== 1'b0 || wbs_dat_o !== 16'h0000) bad++;
                    stray   = 4'($urandom);
                    s_ack_i = (b == delay) ? (stray | oh) : (stray & ~oh);
                    tick();
                end
                s_ack_i = 4'b0000;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("[TB] FAIL rand_busy[%0d]: got %0d bad wait cycles for slave %0d, expected 0", t, bad, n);
                end
            end
            checks++;
            if (wbs_ack_o !== 1'b1 || wbs_dat_o !== exp_dat || s_stb_o !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL rand_ack[%0d]: got ack=%b dat=%h stb=%b, expected 1/%h/0000",
                         t, wbs_ack_o, wbs_dat_o, s_stb_o, exp_dat);
            end
            checks++;
            if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !== {adr, wbs_dat_i, wbs_sel_i, wbs_we_i}) begin
                errors++;
                $display("[TB] FAIL rand_latch[%0d]: got adr=%h dat=%h sel=%b we=%b, expected %h/%h/%b/%b",
                         t, s_adr_o, s_dat_o, s_sel_o, s_we_o, adr, wbs_dat_i, wbs_sel_i, wbs_we_i);
            end
            checks++;
            if (err_o !== exp_err || err_adr_o !== exp_eadr) begin
                errors++;
                $display("[TB] FAIL rand_err[%0d]: got err=%b adr=%h, expected %b/%h", t, err_o, err_adr_o, exp_err, exp_eadr);
            end
            bus_idle();
            tick();
            checks++;
            if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 16'h0000 || s_stb_o !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL rand_turn[%0d]: got ack=%b dat=%h stb=%b, expected 0/0000/0000",
                         t, wbs_ack_o, wbs_dat_o, s_stb_o);
            end
            tick();
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 16'h0;
        wbs_sel_i = 2'b00;
        wbs_we_i  = 1'b0;
        s_dat_i   = 64'h0;
        bus_idle();
        exp_err   = 1'b0;
        exp_eadr  = 32'h0;

        test_reset();
        test_read_slave1();
        test_unmapped_write();
        test_timeout();
        test_abort();
        test_reset_midflight();
        test_back_to_back();
        test_random();

        bus_idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
